ecc_mem_loader: RTL
===================

// Module: ecc_mem_loader
// PURPOSE
//   Write-side master for the ECC operand register file. Takes the byte stream from the
//   SPI receiver and parses each CS frame. It assembles big-endian 32-bit words and issues
//   single-cycle wr_en/cmd_op/wr_addr/wr_d writes into the ECC register file, with address
//   auto-increment. It flags malformed frames (partial word, too many words) to the host
//   status logic.
// PARAMETERS
//   MAX_WORDS  40  max words written per frame; further words are dropped and err_ovf is set
// PORTS
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   frame_start  in   1   1-cycle pulse: SPI CS asserted
//   frame_end    in   1   1-cycle pulse: SPI CS deasserted
//   rx_valid     in   1   1-cycle pulse: rx_data holds a received byte (no backpressure)
//   rx_data      in   8   received byte
//   cmd_op       out  2   operation select for the current write (header bits [7:6])
//   wr_addr      out  6   register word address for the current write
//   wr_d         out  32  write data
//   wr_en        out  1   1-cycle write strobe
//   busy         out  1   1 while a frame is open (state != IDLE)
//   word_cnt     out  6   words written in the current frame (saturates at MAX_WORDS)
//   err_partial  out  1   sticky: frame ended with 1-3 leftover bytes; cleared by frame_start
//   err_ovf      out  1   sticky: more than MAX_WORDS words received; cleared by frame_start
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; internal pointer, byte count and shift register 0.
//   FSM states: IDLE, HEADER, DATA.
//   - any state, frame_start=1: go to HEADER; clear byte_cnt, word_cnt, err_partial, err_ovf.
//     frame_start has priority over frame_end and rx_valid in the same cycle; that byte is ignored.
//   - IDLE: rx_valid and frame_end are ignored.
//   - HEADER, rx_valid: cmd_op <= rx_data[7:6]; ptr <= rx_data[5:0]; go to DATA.
//     HEADER, frame_end: go to IDLE; no write, no error.
//   - DATA, rx_valid: shift the byte in MSB-first (first byte -> wr_d[31:24]); byte_cnt +1 mod 4.
//     On the 4th byte, if word_cnt < MAX_WORDS: on the next clock wr_en=1 for exactly 1 cycle,
//     wr_addr=ptr, wr_d=assembled word; then ptr+1 (6-bit wrap 3F->00), word_cnt+1.
//     If word_cnt == MAX_WORDS: no write; set err_ovf; keep discarding bytes until frame_end.
//   - DATA, frame_end: go to IDLE. If byte_cnt != 0 (after counting a same-cycle byte), set
//     err_partial and discard the partial word.
//     A same-cycle rx_valid is accepted first; a completed word is still written next cycle.
//   - Latency: 4th rx_valid at cycle N -> wr_en at cycle N+1. Back-to-back rx_valid every cycle
//     is supported. wr_en is never asserted on two consecutive cycles.
//   - cmd_op, wr_addr, wr_d hold their last written values between strobes and after frame end.
//   - Async reset mid-frame aborts the frame immediately. Bytes arriving before the next
//     frame_start are ignored.
// TESTING
//   1. start, bytes 40 11 22 33 44 55 66 77 88, end -> wr_en x2: (op1,00,11223344), (op1,01,55667788); no errors
//   2. start, hdr BF, 8 data bytes -> writes at addr 3F then 00 (wrap), cmd_op=2 on both
//   3. start, hdr 00, 6 data bytes, end -> 1 write; err_partial=1; next frame_start -> err_partial=0
//   4. start, hdr 80, 41 words -> 40 writes (addr 00..27); 41st not written; err_ovf=1; word_cnt=40
//   5. rx_valid every cycle; frame_end coincident with the 4th byte -> wr_en the next cycle; err_partial=0
//   6. rst_n low after 2 data bytes -> all outputs 0, busy=0; later bytes without frame_start -> no wr_en

Source files
------------

// File: rtl/ecc_mem_loader_if.sv
// Byte-stream input and register-file write port of the ECC operand loader.
// The master modport is the loader side; the slave modport is the SPI/register-file side.
interface ecc_mem_loader_if;
    logic        frame_start;
    logic        frame_end;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  cmd_op;
    logic [5:0]  wr_addr;
    logic [31:0] wr_d;
    logic        wr_en;
    logic        busy;
    logic [5:0]  word_cnt;
    logic        err_partial;
    logic        err_ovf;

    modport master (
        input  frame_start, frame_end, rx_valid, rx_data,
        output cmd_op, wr_addr, wr_d, wr_en, busy, word_cnt, err_partial, err_ovf
    );

    modport slave (
        output frame_start, frame_end, rx_valid, rx_data,
        input  cmd_op, wr_addr, wr_d, wr_en, busy, word_cnt, err_partial, err_ovf
    );
endinterface

// File: rtl/ecc_mem_loader.sv
// Parses SPI CS frames (header byte + big-endian words) into single-cycle writes to the
// ECC operand register file, with address auto-increment and malformed-frame flags.
module ecc_mem_loader #(
    parameter int unsigned MAX_WORDS = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ecc_mem_loader_if.master      bus
);

    localparam logic [5:0] MAX_WORDS_C = 6'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    logic        err_partial_q, err_partial_d;
    logic        err_ovf_q, err_ovf_d;
    logic [1:0]  cmd_op_q, cmd_op_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_d_q, wr_d_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;

    // Next-state and write-port logic; frame_start overrides everything else.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ptr_d         = ptr_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        word_cnt_d    = word_cnt_q;
        err_partial_d = err_partial_q;
        err_ovf_d     = err_ovf_q;
        cmd_op_d      = cmd_op_q;
        wr_addr_d     = wr_addr_q;
        wr_d_d        = wr_d_q;
        wr_en_d       = 1'b0;

        if (bus.frame_start) begin
            state_d       = S_HEADER;
            byte_cnt_d    = 2'd0;
            word_cnt_d    = 6'd0;
            err_partial_d = 1'b0;
            err_ovf_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_HEADER: begin
                    if (bus.rx_valid) begin
                        op_d  = bus.rx_data[7:6];
                        ptr_d = bus.rx_data[5:0];
                    end else begin
                        op_d  = op_q;
                    end
                    if (bus.frame_end) begin
                        state_d = S_IDLE;
                    end else if (bus.rx_valid) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_HEADER;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        shift_d    = {shift_q[23:0], bus.rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Word complete: write it unless the frame already hit the limit.
                            if (word_cnt_q < MAX_WORDS_C) begin
                                wr_en_d    = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_d_d     = shift_d;
                                cmd_op_d   = op_q;
                                ptr_d      = ptr_q + 6'd1;
                                word_cnt_d = word_cnt_q + 6'd1;
                            end else begin
                                err_ovf_d  = 1'b1;
                            end
                        end else begin
                            wr_en_d = 1'b0;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                    // A same-cycle byte is counted before judging the frame end.
                    if (bus.frame_end) begin
                        state_d = S_IDLE;
                        if (byte_cnt_d != 2'd0) begin
                            err_partial_d = 1'b1;
                        end else begin
                            err_partial_d = err_partial_q;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= 2'd0;
            ptr_q         <= 6'd0;
            byte_cnt_q    <= 2'd0;
            shift_q       <= 32'd0;
            word_cnt_q    <= 6'd0;
            err_partial_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            cmd_op_q      <= 2'd0;
            wr_addr_q     <= 6'd0;
            wr_d_q        <= 32'd0;
            wr_en_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ptr_q         <= ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            word_cnt_q    <= word_cnt_d;
            err_partial_q <= err_partial_d;
            err_ovf_q     <= err_ovf_d;
            cmd_op_q      <= cmd_op_d;
            wr_addr_q     <= wr_addr_d;
            wr_d_q        <= wr_d_d;
            wr_en_q       <= wr_en_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cmd_op      = cmd_op_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_d        = wr_d_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.busy        = busy_q;
    assign bus.word_cnt    = word_cnt_q;
    assign bus.err_partial = err_partial_q;
    assign bus.err_ovf     = err_ovf_q;

endmodule
